// File: rtl/wts_envelope_slot_sequencer.sv
// wts_envelope_slot_sequencer
//   Time-multiplexes five envelope channels (A..E) plus one idle slot over a
//   6-cycle frame. Each channel has a parameter bank and a pending key event.
//   A pending event is presented on the channel's slot and then cleared.
// Ports
//   clk, nreset                       clock, async active-low reset
//   key_on/release/off_req [4:0]      per-channel request pulses
//   reg_wr, reg_ch, reg_addr, reg_wdata  parameter write port
//   active [2:0]                      current slot (5 = idle)
//   ch_key_on/release/off             key event for the slot's channel
//   adsr_en, reg_ar/dr/sr/rr, reg_sl  parameters of the slot's channel
module wts_envelope_slot_sequencer (
  input  logic       clk,
  input  logic       nreset,
  input  logic [4:0] key_on_req,
  input  logic [4:0] key_release_req,
  input  logic [4:0] key_off_req,
  input  logic       reg_wr,
  input  logic [2:0] reg_ch,
  input  logic [2:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic [2:0] active,
  output logic       ch_key_on,
  output logic       ch_key_release,
  output logic       ch_key_off,
  output logic       adsr_en,
  output logic [7:0] reg_ar,
  output logic [7:0] reg_dr,
  output logic [7:0] reg_sr,
  output logic [7:0] reg_rr,
  output logic [5:0] reg_sl
);

  localparam int unsigned NUM_CH   = 5;
  localparam logic [2:0]  NOP_SLOT = 3'd5;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_ON,
    EV_RELEASE,
    EV_OFF
  } event_t;

  logic [7:0]        ar_q [NUM_CH];
  logic [7:0]        dr_q [NUM_CH];
  logic [7:0]        sr_q [NUM_CH];
  logic [7:0]        rr_q [NUM_CH];
  logic [5:0]        sl_q [NUM_CH];
  logic [NUM_CH-1:0] en_q;
  event_t            pend_q [NUM_CH];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      active <= '0;
      en_q   <= '1;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ar_q[i]   <= '0;
        dr_q[i]   <= '0;
        sr_q[i]   <= '0;
        rr_q[i]   <= '0;
        sl_q[i]   <= '0;
        pend_q[i] <= EV_NONE;
      end
    end else begin
      active <= (active == NOP_SLOT) ? '0 : active + 3'd1;

      if (reg_wr && (reg_ch < NOP_SLOT)) begin
        case (reg_addr)
          3'd0:    ar_q[reg_ch] <= reg_wdata;
          3'd1:    dr_q[reg_ch] <= reg_wdata;
          3'd2:    sr_q[reg_ch] <= reg_wdata;
          3'd3:    rr_q[reg_ch] <= reg_wdata;
          3'd4:    sl_q[reg_ch] <= reg_wdata[5:0];
          3'd5:    en_q[reg_ch] <= reg_wdata[0];
          default: ;
        endcase
      end

      // A new request takes precedence over the clear at the end of the
      // delivering slot, so it survives until the next pass of that slot.
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (key_off_req[i])
          pend_q[i] <= EV_OFF;
        else if (key_on_req[i])
          pend_q[i] <= EV_ON;
        else if (key_release_req[i])
          pend_q[i] <= EV_RELEASE;
        else if (active == 3'(i))
          pend_q[i] <= EV_NONE;
      end
    end
  end

  always_comb begin
    ch_key_on      = 1'b0;
    ch_key_release = 1'b0;
    ch_key_off     = 1'b0;
    adsr_en        = 1'b0;
    reg_ar         = '0;
    reg_dr         = '0;
    reg_sr         = '0;
    reg_rr         = '0;
    reg_sl         = '0;
    if (active < NOP_SLOT) begin
      adsr_en = en_q[active];
      reg_ar  = ar_q[active];
      reg_dr  = dr_q[active];
      reg_sr  = sr_q[active];
      reg_rr  = rr_q[active];
      reg_sl  = sl_q[active];
      case (pend_q[active])
        EV_ON:      ch_key_on      = 1'b1;
        EV_RELEASE: ch_key_release = 1'b1;
        EV_OFF:     ch_key_off     = 1'b1;
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_wts_envelope_slot_sequencer.sv
module tb_wts_envelope_slot_sequencer;

  logic       clk = 1'b0;
  logic       nreset;
  logic [4:0] key_on_req, key_release_req, key_off_req;
  logic       reg_wr;
  logic [2:0] reg_ch, reg_addr;
  logic [7:0] reg_wdata;
  logic [2:0] active;
  logic       ch_key_on, ch_key_release, ch_key_off, adsr_en;
  logic [7:0] reg_ar, reg_dr, reg_sr, reg_rr;
  logic [5:0] reg_sl;

  wts_envelope_slot_sequencer dut (
    .clk             (clk),
    .nreset          (nreset),
    .key_on_req      (key_on_req),
    .key_release_req (key_release_req),
    .key_off_req     (key_off_req),
    .reg_wr          (reg_wr),
    .reg_ch          (reg_ch),
    .reg_addr        (reg_addr),
    .reg_wdata       (reg_wdata),
    .active          (active),
    .ch_key_on       (ch_key_on),
    .ch_key_release  (ch_key_release),
    .ch_key_off      (ch_key_off),
    .adsr_en         (adsr_en),
    .reg_ar          (reg_ar),
    .reg_dr          (reg_dr),
    .reg_sr          (reg_sr),
    .reg_rr          (reg_rr),
    .reg_sl          (reg_sl)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: m_e counts clock edges since reset release, so the slot of the
  // current cycle is m_e % 6. A captured request is scheduled for delivery in
  // the first cycle index >= capture with the channel's slot number.
  int m_e;
  int m_ar [5], m_dr [5], m_sr [5], m_rr [5], m_sl [5], m_en [5];
  int m_ev [5];   // 0 none, 1 on, 2 release, 3 off
  int m_due [5];
  int e_old;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_e = 0;
      for (int n = 0; n < 5; n++) begin
        m_ar[n] = 0; m_dr[n] = 0; m_sr[n] = 0; m_rr[n] = 0; m_sl[n] = 0;
        m_en[n] = 1; m_ev[n] = 0; m_due[n] = 0;
      end
    end else begin
      e_old = m_e;
      m_e   = m_e + 1;
      for (int n = 0; n < 5; n++) begin
        if (m_ev[n] != 0 && m_due[n] <= e_old) m_ev[n] = 0;
        if (key_off_req[n] || key_on_req[n] || key_release_req[n]) begin
          m_ev[n]  = key_off_req[n] ? 3 : (key_on_req[n] ? 1 : 2);
          m_due[n] = m_e + ((n - (m_e % 6)) + 6) % 6;
        end
      end
      if (reg_wr && reg_ch < 5) begin
        case (reg_addr)
          3'd0: m_ar[reg_ch] = reg_wdata;
          3'd1: m_dr[reg_ch] = reg_wdata;
          3'd2: m_sr[reg_ch] = reg_wdata;
          3'd3: m_rr[reg_ch] = reg_wdata;
          3'd4: m_sl[reg_ch] = reg_wdata % 64;
          3'd5: m_en[reg_ch] = reg_wdata % 2;
          default: ;
        endcase
      end
    end
  end

  int x_a, x_ev;

  always @(negedge clk) begin
    x_a  = m_e % 6;
    x_ev = 0;
    if (x_a < 5 && m_ev[x_a] != 0 && m_due[x_a] == m_e) x_ev = m_ev[x_a];
    chk("active", active, x_a);
    chk("ch_key_on", ch_key_on, x_ev == 1);
    chk("ch_key_release", ch_key_release, x_ev == 2);
    chk("ch_key_off", ch_key_off, x_ev == 3);
    chk("adsr_en", adsr_en, x_a < 5 ? m_en[x_a] : 0);
    chk("reg_ar", reg_ar, x_a < 5 ? m_ar[x_a] : 0);
    chk("reg_dr", reg_dr, x_a < 5 ? m_dr[x_a] : 0);
    chk("reg_sr", reg_sr, x_a < 5 ? m_sr[x_a] : 0);
    chk("reg_rr", reg_rr, x_a < 5 ? m_rr[x_a] : 0);
    chk("reg_sl", reg_sl, x_a < 5 ? m_sl[x_a] : 0);
  end

  // Advance to the next cycle and drop all one-cycle strobes.
  task automatic step();
    @(posedge clk);
    #2;
    key_on_req = '0; key_release_req = '0; key_off_req = '0; reg_wr = 1'b0;
  endtask

  task automatic goto_slot(input int s);
    int k = 0;
    step();
    while ((m_e % 6) != s && k < 7) begin
      step();
      k++;
    end
  endtask

  task automatic wr(input int ch, input int addr, input int data);
    step();
    reg_wr = 1'b1; reg_ch = 3'(ch); reg_addr = 3'(addr); reg_wdata = 8'(data);
  endtask

  // Observe key outputs for ncyc cycles; index 0 is the current cycle.
  task automatic watch(input int ncyc, output int f_on, output int f_rel, output int f_off,
                       output int n_on, output int n_rel, output int n_off);
    f_on = -1; f_rel = -1; f_off = -1; n_on = 0; n_rel = 0; n_off = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (ch_key_on)      begin if (f_on  < 0) f_on  = i; n_on++;  end
      if (ch_key_release) begin if (f_rel < 0) f_rel = i; n_rel++; end
      if (ch_key_off)     begin if (f_off < 0) f_off = i; n_off++; end
      if (i < ncyc - 1) step();
    end
  endtask

  int f_on, f_rel, f_off, n_on, n_rel, n_off;

  initial begin
    nreset = 1'b0;
    key_on_req = '0; key_release_req = '0; key_off_req = '0;
    reg_wr = 1'b0; reg_ch = '0; reg_addr = '0; reg_wdata = '0;
    repeat (3) @(posedge clk);
    #2 nreset = 1'b1;

    // Idle frame: slot sequence from 0, period 6.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("active_seq", active, i % 6);
    end
    repeat (48) @(negedge clk);

    // Parameter bank of channel 2.
    wr(2, 0, 2); wr(2, 1, 3); wr(2, 4, 60); wr(2, 2, 100); wr(2, 3, 4);
    goto_slot(2);
    @(negedge clk);
    chk("lit_ar_ch2", reg_ar, 2);
    chk("lit_dr_ch2", reg_dr, 3);
    chk("lit_sl_ch2", reg_sl, 60);
    chk("lit_sr_ch2", reg_sr, 100);
    chk("lit_rr_ch2", reg_rr, 4);
    goto_slot(3);
    @(negedge clk);
    chk("lit_ar_ch3", reg_ar, 0);

    // Invalid targets, SL truncation, ADSR_EN clear, write while slot current.
    wr(5, 0, 8'hFF); wr(0, 6, 8'hAA); wr(1, 7, 8'h55);
    wr(4, 4, 8'hFF); wr(3, 5, 8'h00);
    goto_slot(4);
    @(negedge clk);
    chk("lit_sl_trunc", reg_sl, 63);
    goto_slot(0);
    reg_wr = 1'b1; reg_ch = 3'd0; reg_addr = 3'd0; reg_wdata = 8'd9;
    goto_slot(3);
    @(negedge clk);
    chk("lit_adsr_en_off", adsr_en, 0);
    repeat (8) step();

    // ON for ch1 while slot 3 is current: delivered 4 cycles later, once.
    goto_slot(3);
    key_on_req = 5'b00010;
    watch(17, f_on, f_rel, f_off, n_on, n_rel, n_off);
    chk("on_latency", f_on, 4);
    chk("on_count", n_on, 1);
    chk("on_other", n_rel + n_off, 0);

    // Latest request wins: ON then OFF before slot 0.
    goto_slot(2);
    key_on_req = 5'b00001;
    step();
    key_off_req = 5'b00001;
    watch(10, f_on, f_rel, f_off, n_on, n_rel, n_off);
    chk("latest_off_at", f_off, 3);
    chk("latest_off_cnt", n_off, 1);
    chk("latest_on_cnt", n_on, 0);

    // Same-cycle on+release+off: OFF has priority.
    goto_slot(4);
    key_on_req = 5'b00001; key_release_req = 5'b00001; key_off_req = 5'b00001;
    watch(8, f_on, f_rel, f_off, n_on, n_rel, n_off);
    chk("prio_off_at", f_off, 2);
    chk("prio_on_rel", n_on + n_rel, 0);

    // Release arriving during ch4's ON delivery is kept for the next pass.
    goto_slot(1);
    key_on_req = 5'b10000;
    goto_slot(4);
    key_release_req = 5'b10000;
    watch(14, f_on, f_rel, f_off, n_on, n_rel, n_off);
    chk("coll_on_at", f_on, 0);
    chk("coll_rel_at", f_rel, 6);
    chk("coll_rel_cnt", n_rel, 1);

    // Reset mid-operation discards pending ON for ch3 and clears the banks.
    wr(1, 0, 77); wr(1, 5, 0);
    goto_slot(0);
    key_on_req = 5'b01000;
    step();
    nreset = 1'b0;
    step();
    step();
    nreset = 1'b1;
    @(negedge clk);
    chk("rst_active0", active, 0);
    watch(20, f_on, f_rel, f_off, n_on, n_rel, n_off);
    chk("rst_no_keys", n_on + n_rel + n_off, 0);
    goto_slot(1);
    @(negedge clk);
    chk("rst_ar_ch1", reg_ar, 0);
    chk("rst_en_ch1", adsr_en, 1);
    goto_slot(2);
    @(negedge clk);
    chk("rst_sl_ch2", reg_sl, 0);

    repeat (3) step();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
